// File: rtl/tlb_op_ctrl.sv
// CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) plus the CP0 Random counter.
// Optional feature: define TLB_OP_FLUSH_EN to insert a one-cycle MMU flush after each TLB write.
module tlb_op_ctrl #(
    parameter int  TLB_ENTRIES = 16,
    parameter int  ENTRY_W     = 90,
    localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [1:0]         op_type,
    output logic               op_ready,
    output logic               busy,
    input  logic [IDX_W-1:0]   cp0_index,
    input  logic [IDX_W-1:0]   cp0_wired,
    input  logic               cp0_wired_we,
    input  logic [31:0]        cp0_entry_hi,
    input  logic [ENTRY_W-1:0] cp0_entry_wdata,
    output logic [IDX_W-1:0]   random,
    output logic               done,
    output logic [IDX_W:0]     probe_index,
    output logic [ENTRY_W-1:0] read_entry,
    output logic [IDX_W-1:0]   tlbrw_index,
    output logic               tlbrw_we,
    output logic [ENTRY_W-1:0] tlbrw_wdata,
    input  logic [ENTRY_W-1:0] tlbrw_rdata,
    output logic [31:0]        tlbp_entry_hi,
    input  logic [IDX_W:0]     tlbp_index,
    output logic               mmu_flush
);

    localparam logic [1:0]       OP_TLBP  = 2'b00;
    localparam logic [1:0]       OP_TLBR  = 2'b01;
    localparam logic [1:0]       OP_TLBWR = 2'b11;
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [2:0] {IDLE, PROBE, READ, WRITE, FLUSH, DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   random_q, random_d;
    logic [31:0]        hi_q, hi_d;
    logic [ENTRY_W-1:0] wdata_q, wdata_d;
    logic [ENTRY_W-1:0] rentry_q, rentry_d;
    logic [IDX_W:0]     pidx_q, pidx_d;
    logic               accept;

    assign op_ready = (state_q == IDLE);
    assign accept   = op_valid && op_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_type)
                        OP_TLBP: state_d = PROBE;
                        OP_TLBR: state_d = READ;
                        default: state_d = WRITE;
                    endcase
                end
            end
            PROBE:   state_d = DONE;
            READ:    state_d = DONE;
`ifdef TLB_OP_FLUSH_EN
            WRITE:   state_d = FLUSH;
`else
            WRITE:   state_d = DONE;
`endif
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        wdata_d  = wdata_q;
        pidx_d   = pidx_q;
        rentry_d = rentry_q;
        if (accept) begin
            op_d    = op_type;
            idx_d   = (op_type == OP_TLBWR) ? random_q : cp0_index;
            hi_d    = cp0_entry_hi;
            wdata_d = cp0_entry_wdata;
        end
        if (state_q == PROBE && op_q == OP_TLBP) pidx_d = tlbp_index;
        if (state_q == READ && op_q == OP_TLBR) rentry_d = tlbrw_rdata;
    end

    // Wired write wins; a Wired at or above the top entry pins Random at the top.
    always_comb begin
        random_d = random_q - 1'b1;
        if (cp0_wired_we || cp0_wired >= RAND_TOP || random_q == cp0_wired) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_TLBP;
            idx_q    <= '0;
            random_q <= RAND_TOP;
            hi_q     <= '0;
            wdata_q  <= '0;
            pidx_q   <= '0;
            rentry_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            random_q <= random_d;
            hi_q     <= hi_d;
            wdata_q  <= wdata_d;
            pidx_q   <= pidx_d;
            rentry_q <= rentry_d;
        end
    end

    // Strobes are gated by reset so a reset landing mid-op never commits a write.
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign tlbrw_we      = (state_q == WRITE) && reset;
`ifdef TLB_OP_FLUSH_EN
    assign mmu_flush     = (state_q == FLUSH) && reset;
`else
    assign mmu_flush     = 1'b0;
`endif
    assign random        = random_q;
    assign probe_index   = pidx_q;
    assign read_entry    = rentry_q;
    assign tlbrw_index   = idx_q;
    assign tlbrw_wdata   = wdata_q;
    assign tlbp_entry_hi = hi_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl; expectations follow TLB_OP_FLUSH_EN if defined.
module tb_tlb_op_ctrl;

    localparam int N  = 16;
    localparam int EW = 90;
    localparam int IW = 4;
`ifdef TLB_OP_FLUSH_EN
    localparam int FLUSH_ON = 1;
`else
    localparam int FLUSH_ON = 0;
`endif
    localparam int EXP_WLAT   = FLUSH_ON ? 3 : 2;
    localparam int EXP_FL_CYC = FLUSH_ON ? 2 : 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          busy;
    logic [IW-1:0] cp0_index;
    logic [IW-1:0] cp0_wired;
    logic          cp0_wired_we;
    logic [31:0]   cp0_entry_hi;
    logic [EW-1:0] cp0_entry_wdata;
    logic [IW-1:0] random;
    logic          done;
    logic [IW:0]   probe_index;
    logic [EW-1:0] read_entry;
    logic [IW-1:0] tlbrw_index;
    logic          tlbrw_we;
    logic [EW-1:0] tlbrw_wdata;
    logic [EW-1:0] tlbrw_rdata;
    logic [31:0]   tlbp_entry_hi;
    logic [IW:0]   probe_ret;
    logic          mmu_flush;

    logic [EW-1:0] tlb_mem [N];
    assign tlbrw_rdata = tlb_mem[tlbrw_index];

    int checks   = 0;
    int failures = 0;

    // Observations gathered by run_op
    int            r_lat, r_we_cnt, r_fl_cnt, r_fl_cyc;
    logic [IW-1:0] r_we_idx, r_c1_idx;
    logic [EW-1:0] r_we_data;
    logic [31:0]   r_c1_hi;
    logic          r_c1_busy;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLB_ENTRIES(N), .ENTRY_W(EW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .busy(busy), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
        .cp0_wired_we(cp0_wired_we), .cp0_entry_hi(cp0_entry_hi),
        .cp0_entry_wdata(cp0_entry_wdata), .random(random), .done(done),
        .probe_index(probe_index), .read_entry(read_entry), .tlbrw_index(tlbrw_index),
        .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
        .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(probe_ret), .mmu_flush(mmu_flush)
    );

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE, scrambles the request inputs after acceptance and
    // watches the DUT until done (bounded).
    task run_op(input logic [1:0] t);
        op_type   = t;
        op_valid  = 1'b1;
        r_lat     = -1;
        r_we_cnt  = 0;
        r_fl_cnt  = 0;
        r_fl_cyc  = 0;
        r_we_idx  = '0;
        r_we_data = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                r_c1_idx  = tlbrw_index;
                r_c1_hi   = tlbp_entry_hi;
                r_c1_busy = busy;
            end
            if (tlbrw_we) begin
                r_we_cnt++;
                r_we_idx  = tlbrw_index;
                r_we_data = tlbrw_wdata;
            end
            if (mmu_flush) begin
                r_fl_cnt++;
                r_fl_cyc = c;
            end
            if (done) begin
                r_lat = c;
                break;
            end
            if (c == 1) begin
                op_valid        = 1'b0;
                cp0_index       = ~cp0_index;
                cp0_entry_hi    = ~cp0_entry_hi;
                cp0_entry_wdata = ~cp0_entry_wdata;
            end
        end
        op_valid = 1'b0;
    endtask

    task test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, tlbrw_we, mmu_flush, op_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl got busy/done/we/flush/ready=%b exp=00001",
                     {busy, done, tlbrw_we, mmu_flush, op_ready});
        end
        checks++;
        if ({probe_index, read_entry, tlbrw_index, tlbrw_wdata, tlbp_entry_hi} !== '0) begin
            failures++;
            $display("FAIL reset_data got pidx=%h rentry=%h idx=%h wdata=%h hi=%h exp all 0",
                     probe_index, read_entry, tlbrw_index, tlbrw_wdata, tlbp_entry_hi);
        end
        checks++;
        if (random !== 4'd15) begin
            failures++;
            $display("FAIL reset_random got=%0d exp=15", random);
        end
        reset = 1'b1;
    endtask

    task test_random();
        cp0_wired    = 4'd4;
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        checks++;
        if (random !== 4'd15) begin
            failures++;
            $display("FAIL rand_load got=%0d exp=15", random);
        end
        for (int e = 14; e >= 4; e--) begin
            tick();
            checks++;
            if (random !== IW'(e)) begin
                failures++;
                $display("FAIL rand_seq got=%0d exp=%0d", random, e);
            end
        end
        tick();
        checks++;
        if (random !== 4'd15) begin
            failures++;
            $display("FAIL rand_wrap got=%0d exp=15", random);
        end
        tick();
        tick();
        checks++;
        if (random !== 4'd13) begin
            failures++;
            $display("FAIL rand_after_wrap got=%0d exp=13", random);
        end
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        checks++;
        if (random !== 4'd15) begin
            failures++;
            $display("FAIL rand_wired_we got=%0d exp=15", random);
        end
        tick();
        cp0_wired = 4'd15;
        tick();
        tick();
        tick();
        checks++;
        if (random !== 4'd15) begin
            failures++;
            $display("FAIL rand_hold_wired15 got=%0d exp=15", random);
        end
        cp0_wired = 4'd4;
    endtask

    task test_probe();
        probe_ret    = 5'b0_0011;
        cp0_entry_hi = 32'h1234_5000;
        run_op(2'b00);
        checks++;
        if (r_lat !== 2) begin
            failures++;
            $display("FAIL probe_latency got=%0d exp=2", r_lat);
        end
        checks++;
        if (r_c1_hi !== 32'h1234_5000 || r_c1_busy !== 1'b1) begin
            failures++;
            $display("FAIL probe_key got hi=%h busy=%b exp hi=12345000 busy=1", r_c1_hi, r_c1_busy);
        end
        checks++;
        if (probe_index !== 5'b0_0011) begin
            failures++;
            $display("FAIL probe_hit got=%b exp=00011", probe_index);
        end
        tick();
        checks++;
        if ({done, op_ready} !== 2'b01) begin
            failures++;
            $display("FAIL probe_done_pulse got done/ready=%b exp=01", {done, op_ready});
        end
        probe_ret    = 5'b1_0110;
        cp0_entry_hi = 32'h0000_0abc;
        run_op(2'b00);
        checks++;
        if (r_lat !== 2 || probe_index !== 5'b1_0110) begin
            failures++;
            $display("FAIL probe_miss got lat=%0d pidx=%b exp lat=2 pidx=10110", r_lat, probe_index);
        end
        tick();
    endtask

    task test_read();
        cp0_index = 4'd7;
        run_op(2'b01);
        checks++;
        if (r_c1_idx !== 4'd7 || r_lat !== 2) begin
            failures++;
            $display("FAIL read_index got idx=%0d lat=%0d exp idx=7 lat=2", r_c1_idx, r_lat);
        end
        checks++;
        if (read_entry !== 90'hABC) begin
            failures++;
            $display("FAIL read_entry got=%h exp=abc", read_entry);
        end
        checks++;
        if (probe_index !== 5'b1_0110 || r_we_cnt !== 0) begin
            failures++;
            $display("FAIL read_side got pidx=%b we_cnt=%0d exp pidx=10110 we_cnt=0",
                     probe_index, r_we_cnt);
        end
        tick();
    endtask

    task test_write_index();
        cp0_index       = 4'd2;
        cp0_entry_wdata = 90'h3_0000_1111_2222_3333_4444;
        run_op(2'b10);
        checks++;
        if (r_we_cnt !== 1 || r_we_idx !== 4'd2 || r_we_data !== 90'h3_0000_1111_2222_3333_4444) begin
            failures++;
            $display("FAIL tlbwi_write got cnt=%0d idx=%0d data=%h exp cnt=1 idx=2 data=30000111122223333444 4",
                     r_we_cnt, r_we_idx, r_we_data);
        end
        checks++;
        if (r_lat !== EXP_WLAT) begin
            failures++;
            $display("FAIL tlbwi_latency got=%0d exp=%0d", r_lat, EXP_WLAT);
        end
        checks++;
        if (r_fl_cnt !== FLUSH_ON || r_fl_cyc !== EXP_FL_CYC) begin
            failures++;
            $display("FAIL tlbwi_flush got cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d",
                     r_fl_cnt, r_fl_cyc, FLUSH_ON, EXP_FL_CYC);
        end
        tick();
    endtask

    task test_write_random();
        cp0_wired_we = 1'b1;
        tick();
        cp0_wired_we = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (random !== 4'd9) begin
            failures++;
            $display("FAIL tlbwr_setup got random=%0d exp=9", random);
        end
        cp0_index       = 4'd3;
        cp0_entry_wdata = 90'h155;
        run_op(2'b11);
        checks++;
        if (r_we_cnt !== 1 || r_we_idx !== 4'd9 || r_we_data !== 90'h155) begin
            failures++;
            $display("FAIL tlbwr_write got cnt=%0d idx=%0d data=%h exp cnt=1 idx=9 data=155",
                     r_we_cnt, r_we_idx, r_we_data);
        end
        checks++;
        if (random !== IW'(9 - EXP_WLAT)) begin
            failures++;
            $display("FAIL tlbwr_random_moves got=%0d exp=%0d", random, 9 - EXP_WLAT);
        end
        tick();
    endtask

    task test_back_to_back();
        op_type  = 2'b00;
        op_valid = 1'b1;
        tick();
        checks++;
        if ({busy, op_ready} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_c1 got busy/ready=%b exp=10", {busy, op_ready});
        end
        tick();
        checks++;
        if ({done, op_ready} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_c2 got done/ready=%b exp=10", {done, op_ready});
        end
        tick();
        checks++;
        if ({done, op_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_c3 got done/ready=%b exp=01", {done, op_ready});
        end
        tick();
        op_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_accept got busy=%b exp=1", busy);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_done got=%b exp=1", done);
        end
        tick();
    endtask

    task test_reset_mid_write();
        int done_cnt, we_cnt, nready_cnt;
        cp0_index       = 4'd5;
        cp0_entry_wdata = 90'h77;
        op_type         = 2'b10;
        op_valid        = 1'b1;
        tick();
        op_valid = 1'b0;
        checks++;
        if (tlbrw_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_in_write got we=%b exp=1", tlbrw_we);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tlbrw_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_we_gated got=%b exp=0", tlbrw_we);
        end
        tick();
        checks++;
        if ({busy, done, tlbrw_we, mmu_flush} !== 4'b0 || random !== 4'd15 ||
            {probe_index, read_entry, tlbrw_index, tlbrw_wdata, tlbp_entry_hi} !== '0) begin
            failures++;
            $display("FAIL rst_mid_values got ctrl=%b rnd=%0d pidx=%h rentry=%h idx=%h wdata=%h hi=%h exp zeros rnd=15",
                     {busy, done, tlbrw_we, mmu_flush}, random, probe_index, read_entry,
                     tlbrw_index, tlbrw_wdata, tlbp_entry_hi);
        end
        reset = 1'b1;
        checks++;
        if (op_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b exp=1", op_ready);
        end
        done_cnt   = 0;
        we_cnt     = 0;
        nready_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_cnt++;
            if (tlbrw_we) we_cnt++;
            if (!op_ready) nready_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || we_cnt !== 0 || nready_cnt !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got done=%0d we=%0d not_ready=%0d exp 0 0 0",
                     done_cnt, we_cnt, nready_cnt);
        end
    endtask

    initial begin
        reset           = 1'b0;
        op_valid        = 1'b0;
        op_type         = 2'b00;
        cp0_index       = '0;
        cp0_wired       = '0;
        cp0_wired_we    = 1'b0;
        cp0_entry_hi    = '0;
        cp0_entry_wdata = '0;
        probe_ret       = '0;
        for (int i = 0; i < N; i++) tlb_mem[i] = EW'(i * 4096 + 17);
        tlb_mem[7] = 90'hABC;

        test_reset();
        test_random();
        test_probe();
        test_read();
        test_write_index();
        test_write_random();
        test_back_to_back();
        test_reset_mid_write();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
